// File: rtl/dpram_rr_arbiter.sv
// rtl/dpram_rr_arbiter.sv - round-robin write/read port arbiter in front of a 1W/1R dual-port RAM
//
// Purpose: shares one dpram (single write port, single read port) among NUM_REQ
// clients. Each RAM port has its own round-robin arbiter. The winning command is
// registered onto the RAM pins, and each read response is routed back to the
// client that issued it.
//
// Optional feature macro: DPRAM_ARB_FWD_EN. When it is defined, a read and a write
// to the same address in the same RAM cycle return the newly written data.
//
// Ports:
//   clk, reset           : clock; asynchronous active-low reset
//   wr_req/wr_addr/wr_data/wr_gnt : per-client write command, combinational one-hot grant
//   rd_req/rd_addr/rd_gnt         : per-client read command, combinational one-hot grant
//   rd_valid/rd_data     : one-hot response strobe; shared response data
//   mem_we/mem_wr_addr/mem_data_in/mem_re/mem_rd_addr/mem_data_out : RAM pins
`timescale 1ns/1ps
module dpram_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 6,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    wr_req,
    input  logic [NUM_REQ*AW-1:0] wr_addr,
    input  logic [NUM_REQ*DW-1:0] wr_data,
    output logic [NUM_REQ-1:0]    wr_gnt,
    input  logic [NUM_REQ-1:0]    rd_req,
    input  logic [NUM_REQ*AW-1:0] rd_addr,
    output logic [NUM_REQ-1:0]    rd_gnt,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [DW-1:0]         rd_data,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [DW-1:0]         mem_data_in,
    output logic                  mem_re,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DW-1:0]         mem_data_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    // Search starts at the client after ptr and wraps around, so the most recent
    // winner gets the lowest priority on the next cycle.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [IW-1:0] ptr);
        logic [NUM_REQ-1:0] gnt;
        logic [IW-1:0]      idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [IW-1:0] enc(input logic [NUM_REQ-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    logic [IW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]  wr_win, rd_win;
    logic           wr_any, rd_any;

    logic           mem_we_q;
    logic [AW-1:0]  mem_wr_addr_q;
    logic [DW-1:0]  mem_data_in_q;
    logic [AW-1:0]  mem_rd_addr_q;

    // Stage 0 of the tag pipeline is in step with mem_re. Stage RD_LAT is in step with
    // the RAM's data_out.
    logic [RD_LAT:0] tag_v_q;
    logic [IW-1:0]   tag_idx_q [0:RD_LAT];

    always_comb begin
        wr_gnt   = rr_pick(wr_req, wr_ptr_q);
        rd_gnt   = rr_pick(rd_req, rd_ptr_q);
        wr_any   = |wr_gnt;
        rd_any   = |rd_gnt;
        wr_win   = enc(wr_gnt);
        rd_win   = enc(rd_gnt);
        wr_ptr_d = wr_any ? wr_win : wr_ptr_q;
        rd_ptr_d = rd_any ? rd_win : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= LAST_IDX;
            rd_ptr_q      <= LAST_IDX;
            mem_we_q      <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_data_in_q <= '0;
            mem_rd_addr_q <= '0;
            tag_v_q       <= '0;
            for (int k = 0; k <= RD_LAT; k++) tag_idx_q[k] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_we_q   <= wr_any;
            tag_v_q[0] <= rd_any;
            if (wr_any) begin
                mem_wr_addr_q <= wr_addr[wr_win*AW +: AW];
                mem_data_in_q <= wr_data[wr_win*DW +: DW];
            end
            if (rd_any) begin
                mem_rd_addr_q <= rd_addr[rd_win*AW +: AW];
                tag_idx_q[0]  <= rd_win;
            end
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_v_q[k]   <= tag_v_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_re      = tag_v_q[0];
    assign mem_rd_addr = mem_rd_addr_q;

    assign rd_valid = tag_v_q[RD_LAT] ? (NUM_REQ'(1) << tag_idx_q[RD_LAT]) : '0;

`ifdef DPRAM_ARB_FWD_EN
    // A collision is detected in the cycle the RAM sees both commands. The write data
    // then travels alongside the read tag and replaces the RAM's old-data output.
    logic [RD_LAT:1] fwd_v_q;
    logic [DW-1:0]   fwd_d_q [1:RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_v_q <= '0;
            for (int k = 1; k <= RD_LAT; k++) fwd_d_q[k] <= '0;
        end else begin
            fwd_v_q[1] <= mem_we_q & tag_v_q[0] & (mem_wr_addr_q == mem_rd_addr_q);
            fwd_d_q[1] <= mem_data_in_q;
            for (int k = 2; k <= RD_LAT; k++) begin
                fwd_v_q[k] <= fwd_v_q[k-1];
                fwd_d_q[k] <= fwd_d_q[k-1];
            end
        end
    end

    assign rd_data = !tag_v_q[RD_LAT]  ? '0 :
                     fwd_v_q[RD_LAT]   ? fwd_d_q[RD_LAT] : mem_data_out;
`else
    assign rd_data = tag_v_q[RD_LAT] ? mem_data_out : '0;
`endif

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Shares the single-write/single-read dual-port RAM (`dpram`, 64x8) among NUM_REQ requesters.
- Two independent round-robin arbiters: one for the write port, one for the read port.
- Registers the winning command onto the RAM pins.
- Tracks read latency and routes each read response back to the requester that issued it.
- Sits between client blocks and `dpram`, in place of direct drive of we/re/addr.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- AW, 6: RAM address width.
- DW, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles, from mem_re sampled to data_out valid (1..3).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_req  input  NUM_REQ  per-requester write request.
- wr_addr  input  NUM_REQ*AW  flattened write addresses; requester i at [i*AW +: AW].
- wr_data  input  NUM_REQ*DW  flattened write data.
- wr_gnt  output  NUM_REQ  one-hot write grant, combinational.
- rd_req  input  NUM_REQ  per-requester read request.
- rd_addr  input  NUM_REQ*AW  flattened read addresses.
- rd_gnt  output  NUM_REQ  one-hot read grant, combinational.
- rd_valid  output  NUM_REQ  one-hot read response strobe.
- rd_data  output  DW  read response data, shared by all requesters, qualified by rd_valid.
- mem_we  output  1  RAM write enable (to dpram we).
- mem_wr_addr  output  AW  to dpram wr_addr.
- mem_data_in  output  DW  to dpram data_in.
- mem_re  output  1  RAM read enable (to dpram re).
- mem_rd_addr  output  AW  to dpram rd_addr.
- mem_data_out  input  DW  from dpram data_out.

Behaviour:
- Reset (reset=0, async): mem_we=0, mem_re=0, mem_wr_addr=0, mem_rd_addr=0, mem_data_in=0, rd_valid=0, rd_data=0.
- On reset, both round-robin pointers go to NUM_REQ-1, so requester 0 has highest priority first.
- Read-tag pipeline and all in-flight responses are cleared. Reads in flight at reset are dropped, never delivered.
- Handshake:
  - A requester holds req plus addr/data stable until it sees gnt=1 in the same cycle.
  - Transfer occurs on the clock edge where req&gnt=1.
  - gnt is never asserted without req.
  - At most one wr_gnt and one rd_gnt bit are set per cycle.
- Arbitration per port:
  - Priority starts at index ptr+1 and wraps modulo NUM_REQ.
  - The first requesting index wins.
  - ptr updates to the winner only on a cycle with a grant; otherwise it holds.
  - Write and read arbiters are fully independent; both may grant in the same cycle.
- Write path: grant in cycle T -> mem_we=1 with the registered addr/data in T+1. mem_we=0 in any cycle following a no-grant cycle.
- Read path:
  - Grant in cycle T -> mem_re=1, mem_rd_addr registered, in T+1.
  - The requester index enters a (RD_LAT)-deep tag shift register.
  - rd_valid[idx]=1 and rd_data=mem_data_out (registered) in cycle T+1+RD_LAT+... total response latency is exactly 2+RD_LAT-1 = RD_LAT+1 cycles after grant, i.e. T+2 for RD_LAT=1.
- Throughput: back-to-back grants every cycle on each port; no bubbles.
- Unaligned/out-of-range conditions do not exist: addresses are full AW-bit; wrap is the RAM's natural modulo 2^AW.
- Same address, same cycle at the RAM (mem_we & mem_re & addrs equal) without the optional feature: rd_data returns the RAM's pre-write (old) contents.
- All requesters idle -> mem_we=mem_re=0; pointers hold.

Optional Feature:
- Macro: DPRAM_ARB_FWD_EN.
- Defined:
  - When mem_we and mem_re are both high with mem_wr_addr==mem_rd_addr, the write data is captured alongside the read tag.
  - The response returns the new (written) data instead of mem_data_out.
  - Read-after-write to the same address in the same RAM cycle is therefore coherent.
- Undefined: no compare logic; the old-data behaviour above applies.

Test Plan:
- Reset then single write from req0 (addr 0x05, data 0xA5), next cycle read req1 addr 0x05 -> wr_gnt=01 and rd_gnt=10 immediately; mem_we=1 one cycle later; rd_valid=10 with rd_data=0xA5 two cycles after the read grant.
- Both requesters assert wr_req continuously for 6 cycles (distinct addrs) -> wr_gnt alternates 01,10,01,10,01,10; every cycle grants; RAM holds all 6 values on readback.
- Requester 1 issues 4 back-to-back reads (addrs 0x00..0x03, preloaded 0x10..0x13) while requester 0 writes -> rd_valid[1] on 4 consecutive cycles with 0x10,0x11,0x12,0x13 in order; writes unaffected.
- Same-cycle write addr 0x3F data 0x77 and read addr 0x3F (old value 0x11) -> rd_data=0x11 without DPRAM_ARB_FWD_EN, 0x77 with it.
- Reads issued, reset asserted low one cycle after the grant -> rd_valid stays 0 through and after reset; first grant after release goes to requester 0.
- Only requester 1 requests for 3 cycles, then both -> req1 granted 3 times, then req0 wins (ptr=1 so index 0 has priority).
